// File: rtl/dac_tlv5638_sched.sv
// Word scheduler for the TLV5638 serial DAC driver: picks one 16-bit command
// word per serial frame from the channel A/B sample slots and control requests.
module dac_tlv5638_sched #(
    parameter logic [1:0] REF_DEFAULT = 2'b10
) (
    input  logic        clk_20M,
    input  logic        rst_n,
    input  logic        frame_irq,
    input  logic [1:0]  ref_sel,
    input  logic        speed,
    input  logic        pwr_down,
    input  logic        reinit,
    input  logic        a_valid,
    input  logic [11:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [11:0] b_data,
    output logic        b_ready,
    output logic [15:0] config_reg,
    output logic        upd_done,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_PAIR2
    } state_t;

    state_t      state, state_nx;
    logic        irq_d;
    logic        tick;
    logic        a_full, b_full;
    logic [11:0] a_buf, b_buf;
    logic        reinit_pend;
    logic [15:0] word_nx;
    logic [15:0] ctrl_word;
    logic        upd_nx;
    logic        clr_a, clr_b, clr_reinit;

    assign tick      = frame_irq & ~irq_d;
    assign ctrl_word = {1'b1, speed, pwr_down, 1'b1, 10'd0, ref_sel};
    assign a_ready   = ~a_full;
    assign b_ready   = ~b_full;
    assign busy      = (state != ST_IDLE) | a_full | b_full | reinit_pend;

    always_ff @(posedge clk_20M) begin
        if (!rst_n) begin
            state       <= ST_INIT;
            irq_d       <= 1'b0;
            a_full      <= 1'b0;
            b_full      <= 1'b0;
            a_buf       <= 12'd0;
            b_buf       <= 12'd0;
            reinit_pend <= 1'b0;
            config_reg  <= {4'b1001, 10'd0, REF_DEFAULT};
            upd_done    <= 1'b0;
        end else begin
            irq_d      <= frame_irq;
            state      <= state_nx;
            config_reg <= word_nx;
            upd_done   <= upd_nx;

            // A slot emptied by this tick cannot refill on the same edge since ready was low.
            if (clr_a) begin
                a_full <= 1'b0;
            end else if (a_valid && !a_full) begin
                a_full <= 1'b1;
                a_buf  <= a_data;
            end

            if (clr_b) begin
                b_full <= 1'b0;
            end else if (b_valid && !b_full) begin
                b_full <= 1'b1;
                b_buf  <= b_data;
            end

            if (reinit) begin
                reinit_pend <= 1'b1;
            end else if (clr_reinit) begin
                reinit_pend <= 1'b0;
            end
        end
    end

    // Paired updates load B into the buffer first; the A word then moves both outputs together.
    always_comb begin
        state_nx   = state;
        word_nx    = config_reg;
        upd_nx     = 1'b0;
        clr_a      = 1'b0;
        clr_b      = 1'b0;
        clr_reinit = 1'b0;
        if (tick) begin
            case (state)
                ST_INIT: begin
                    word_nx    = ctrl_word;
                    clr_reinit = 1'b1;
                    state_nx   = ST_IDLE;
                end
                ST_IDLE: begin
                    if (reinit_pend) begin
                        word_nx    = ctrl_word;
                        clr_reinit = 1'b1;
                    end else if (a_full && b_full) begin
                        word_nx  = {1'b0, speed, pwr_down, 1'b1, b_buf};
                        clr_b    = 1'b1;
                        state_nx = ST_PAIR2;
                    end else if (b_full) begin
                        word_nx = {1'b0, speed, pwr_down, 1'b0, b_buf};
                        clr_b   = 1'b1;
                        upd_nx  = 1'b1;
                    end else if (a_full) begin
                        word_nx = {1'b1, speed, pwr_down, 1'b0, a_buf};
                        clr_a   = 1'b1;
                        upd_nx  = 1'b1;
                    end else begin
                        word_nx    = ctrl_word;
                        clr_reinit = 1'b1;
                    end
                end
                ST_PAIR2: begin
                    word_nx  = {1'b1, speed, pwr_down, 1'b0, a_buf};
                    clr_a    = 1'b1;
                    upd_nx   = 1'b1;
                    state_nx = ST_IDLE;
                end
                default: begin
                    state_nx = ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_tlv5638_sched.sv
// Scoreboard bench for dac_tlv5638_sched: stimulus queues expected frame words,
// a monitor pops and checks them on every frame tick.
module tb_dac_tlv5638_sched;

    logic        clk_20M = 1'b0;
    logic        rst_n;
    logic        frame_irq;
    logic [1:0]  ref_sel;
    logic        speed;
    logic        pwr_down;
    logic        reinit;
    logic        a_valid;
    logic [11:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [11:0] b_data;
    logic        b_ready;
    logic [15:0] config_reg;
    logic        upd_done;
    logic        busy;

    typedef struct {
        logic [15:0] word;
        logic        upd;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    dac_tlv5638_sched #(.REF_DEFAULT(2'b10)) dut (
        .clk_20M    (clk_20M),
        .rst_n      (rst_n),
        .frame_irq  (frame_irq),
        .ref_sel    (ref_sel),
        .speed      (speed),
        .pwr_down   (pwr_down),
        .reinit     (reinit),
        .a_valid    (a_valid),
        .a_data     (a_data),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_data     (b_data),
        .b_ready    (b_ready),
        .config_reg (config_reg),
        .upd_done   (upd_done),
        .busy       (busy)
    );

    always #25 clk_20M = ~clk_20M;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic expectWord(input logic [15:0] word, input logic upd);
        exp_t e;
        e.word = word;
        e.upd  = upd;
        exp_q.push_back(e);
    endtask

    // One serial frame: rising edge of frame_irq, then 20 clocks before returning.
    task automatic frameTick();
        @(negedge clk_20M);
        frame_irq = 1'b1;
        repeat (10) @(negedge clk_20M);
        frame_irq = 1'b0;
        repeat (10) @(negedge clk_20M);
    endtask

    task automatic applyStimulus(input logic is_b, input logic [11:0] data);
        @(negedge clk_20M);
        if (is_b) begin
            b_valid = 1'b1;
            b_data  = data;
        end else begin
            a_valid = 1'b1;
            a_data  = data;
        end
        @(negedge clk_20M);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    // Monitor: a tick is seen at the posedge; the word is checked at the following negedge.
    initial begin : monitor
        logic prev_irq;
        logic tick_now;
        logic tick_last;
        exp_t e;
        prev_irq  = 1'b0;
        tick_last = 1'b0;
        forever begin
            @(posedge clk_20M);
            tick_now = rst_n && frame_irq && !prev_irq;
            prev_irq = rst_n && frame_irq;
            @(negedge clk_20M);
            if (tick_now) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_word: got %h, expected no tick word", config_reg);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("frame_word", config_reg, e.word);
                    checkOutput("upd_done_pulse", {15'd0, upd_done}, {15'd0, e.upd});
                end
            end else if (tick_last) begin
                checkOutput("upd_done_width", {15'd0, upd_done}, 16'd0);
            end
            tick_last = tick_now;
        end
    end

    initial begin : watchdog
        repeat (5000) @(posedge clk_20M);
        mismatched++;
        $display("[TB] FAIL timeout: got no completion, expected finish within 5000 cycles");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        rst_n     = 1'b0;
        frame_irq = 1'b0;
        ref_sel   = 2'b01;
        speed     = 1'b0;
        pwr_down  = 1'b0;
        reinit    = 1'b0;
        a_valid   = 1'b0;
        a_data    = 12'd0;
        b_valid   = 1'b0;
        b_data    = 12'd0;

        repeat (3) @(negedge clk_20M);
        checkOutput("reset_word", config_reg, 16'h9002);
        checkOutput("reset_a_ready", {15'd0, a_ready}, 16'd1);
        checkOutput("reset_b_ready", {15'd0, b_ready}, 16'd1);
        checkOutput("reset_busy", {15'd0, busy}, 16'd1);
        checkOutput("reset_upd", {15'd0, upd_done}, 16'd0);
        rst_n = 1'b1;

        expectWord(16'h9001, 1'b0);
        frameTick();
        checkOutput("init_busy", {15'd0, busy}, 16'd0);

        applyStimulus(1'b0, 12'h5A5);
        checkOutput("a_full_ready", {15'd0, a_ready}, 16'd0);
        expectWord(16'h85A5, 1'b1);
        frameTick();
        checkOutput("a_ready_after", {15'd0, a_ready}, 16'd1);
        expectWord(16'h9001, 1'b0);
        frameTick();

        applyStimulus(1'b1, 12'h123);
        expectWord(16'h0123, 1'b1);
        frameTick();

        applyStimulus(1'b0, 12'hFFF);
        applyStimulus(1'b1, 12'h001);
        expectWord(16'h1001, 1'b0);
        expectWord(16'h8FFF, 1'b1);
        expectWord(16'h0777, 1'b1);
        frameTick();
        applyStimulus(1'b1, 12'h777);
        frameTick();
        frameTick();

        ref_sel = 2'b10;
        applyStimulus(1'b0, 12'h0AA);
        applyStimulus(1'b1, 12'h0BB);
        expectWord(16'h10BB, 1'b0);
        expectWord(16'h80AA, 1'b1);
        expectWord(16'h9002, 1'b0);
        frameTick();
        @(negedge clk_20M);
        reinit = 1'b1;
        @(negedge clk_20M);
        reinit = 1'b0;
        frameTick();
        checkOutput("reinit_busy", {15'd0, busy}, 16'd1);
        frameTick();
        checkOutput("after_reinit_busy", {15'd0, busy}, 16'd0);

        speed = 1'b1;
        applyStimulus(1'b0, 12'h321);
        expectWord(16'hC321, 1'b1);
        expectWord(16'hD002, 1'b0);
        frameTick();
        frameTick();
        speed = 1'b0;

        applyStimulus(1'b0, 12'h456);
        applyStimulus(1'b1, 12'h789);
        expectWord(16'h1789, 1'b0);
        frameTick();
        @(negedge clk_20M);
        rst_n = 1'b0;
        @(negedge clk_20M);
        checkOutput("midpair_word", config_reg, 16'h9002);
        checkOutput("midpair_a_ready", {15'd0, a_ready}, 16'd1);
        checkOutput("midpair_b_ready", {15'd0, b_ready}, 16'd1);
        checkOutput("midpair_busy", {15'd0, busy}, 16'd1);
        rst_n = 1'b1;
        expectWord(16'h9002, 1'b0);
        expectWord(16'h9002, 1'b0);
        frameTick();
        checkOutput("midpair_busy_after", {15'd0, busy}, 16'd0);
        frameTick();

        repeat (5) @(negedge clk_20M);
        checkOutput("queue_drained", exp_q.size() > 0 ? 16'd1 : 16'd0, 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
